// File: rtl/alu_arbiter_pkg.sv
// Shared widths and ALU opcode encoding for the EX-stage ALU arbiter.
package alu_arbiter_pkg;

    localparam int unsigned CPU_WIDTH    = 32;
    localparam int unsigned ALU_OP_WIDTH = 4;

    typedef enum logic [ALU_OP_WIDTH-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: a lone requester always wins, a tie goes to
// the side that did not win last time.
module alu_arbiter_rr_arb2 (
    input  logic [1:0] valid,
    input  logic       en,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            case (valid)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = last ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between the integer pipe (req0) and the
// address/branch helper (req1); results come back through a single slot.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int unsigned DW  = CPU_WIDTH,
    parameter int unsigned OPW = ALU_OP_WIDTH
) (
    input  logic           clk,
    input  logic           rst_n,

    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [OPW-1:0] req0_op,
    input  logic [DW-1:0]  req0_src1,
    input  logic [DW-1:0]  req0_src2,

    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [OPW-1:0] req1_op,
    input  logic [DW-1:0]  req1_src1,
    input  logic [DW-1:0]  req1_src2,

    output logic           rsp0_valid,
    input  logic           rsp0_ready,
    output logic [DW-1:0]  rsp0_res,

    output logic           rsp1_valid,
    input  logic           rsp1_ready,
    output logic [DW-1:0]  rsp1_res,

    output logic [OPW-1:0] alu_op,
    output logic [DW-1:0]  alu_src1,
    output logic [DW-1:0]  alu_src2,
    input  logic [DW-1:0]  alu_res
);

    logic          slot_vld;
    logic          slot_id;
    logic [DW-1:0] slot_res;
    logic          last_gnt;

    logic          slot_free;
    logic [1:0]    gnt;
    logic          accept;

    // The slot can take a new result if empty or being drained this cycle.
    assign slot_free = !slot_vld || (slot_id ? rsp1_ready : rsp0_ready);

    alu_arbiter_rr_arb2 u_rr_arb2 (
        .valid ({req1_valid, req0_valid}),
        .en    (slot_free),
        .last  (last_gnt),
        .gnt   (gnt)
    );

    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];
    assign accept     = |gnt;

    // Idle ALU inputs are forced to ADD 0+0 so nothing toggles downstream.
    always_comb begin
        alu_op   = OPW'(ALU_ADD);
        alu_src1 = '0;
        alu_src2 = '0;
        if (gnt[0]) begin
            alu_op   = req0_op;
            alu_src1 = req0_src1;
            alu_src2 = req0_src2;
        end else if (gnt[1]) begin
            alu_op   = req1_op;
            alu_src1 = req1_src1;
            alu_src2 = req1_src2;
        end
    end

    // last_gnt resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_vld <= 1'b0;
            slot_id  <= 1'b0;
            slot_res <= '0;
            last_gnt <= 1'b1;
        end else if (accept) begin
            slot_vld <= 1'b1;
            slot_id  <= gnt[1];
            slot_res <= alu_res;
            last_gnt <= gnt[1];
        end else if (slot_free) begin
            slot_vld <= 1'b0;
        end
    end

    assign rsp0_valid = slot_vld && !slot_id;
    assign rsp1_valid = slot_vld && slot_id;
    assign rsp0_res   = slot_res;
    assign rsp1_res   = slot_res;

endmodule
